// File: rtl/midi_parser_if.sv
// Byte and message handshake bundle between the UART receiver, the MIDI
// parser and the downstream synth/control logic.
interface midi_parser_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rdy;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic [7:0] drop_cnt;

  modport slave (
    input  rx_rdy, rx_data, msg_ready,
    output clr_rdy, msg_valid, msg_status, msg_data1, msg_data2,
           rt_valid, rt_byte, drop_cnt
  );

  modport master (
    output rx_rdy, rx_data, msg_ready,
    input  clr_rdy, msg_valid, msg_status, msg_data1, msg_data2,
           rt_valid, rt_byte, drop_cnt
  );
endinterface

// File: rtl/midi_parser.sv
// MIDI byte parser: assembles channel-voice messages with running status,
// forwards real-time bytes immediately and counts orphaned data bytes.
module midi_parser (
  input  logic         clk,
  input  logic         rst,
  midi_parser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

  state_t     state_q;
  logic [7:0] run_status_q;
  logic [6:0] data1_q;
  logic       clr_rdy_q;
  logic       msg_valid_q;
  logic [7:0] msg_status_q;
  logic [6:0] msg_data1_q;
  logic [6:0] msg_data2_q;
  logic       rt_valid_q;
  logic [7:0] rt_byte_q;
  logic [7:0] drop_cnt_q;

  logic       stall;
  logic       accept;
  logic       one_data;
  logic [7:0] byte_in;

  assign byte_in  = bus.rx_data;
  assign stall    = msg_valid_q & ~bus.msg_ready;
  // ~clr_rdy_q keeps the byte from being taken twice while the UART drops rdy
  assign accept   = bus.rx_rdy & ~clr_rdy_q & ~stall;
  // Program change and channel pressure (0xC0-0xDF) carry one data byte
  assign one_data = (run_status_q[7:5] == 3'b110);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      run_status_q <= 8'h00;
      data1_q      <= 7'h00;
      clr_rdy_q    <= 1'b0;
      msg_valid_q  <= 1'b0;
      msg_status_q <= 8'h00;
      msg_data1_q  <= 7'h00;
      msg_data2_q  <= 7'h00;
      rt_valid_q   <= 1'b0;
      rt_byte_q    <= 8'h00;
      drop_cnt_q   <= 8'h00;
    end else begin
      clr_rdy_q  <= accept;
      rt_valid_q <= 1'b0;
      if (msg_valid_q && bus.msg_ready) msg_valid_q <= 1'b0;

      if (accept) begin
        if (byte_in >= 8'hF8) begin
          rt_valid_q <= 1'b1;
          rt_byte_q  <= byte_in;
        end else if (byte_in >= 8'hF0) begin
          run_status_q <= 8'h00;
          state_q      <= IDLE;
        end else if (byte_in[7]) begin
          run_status_q <= byte_in;
          state_q      <= WAIT_D1;
        end else begin
          case (state_q)
            IDLE: begin
              if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            WAIT_D1: begin
              data1_q <= byte_in[6:0];
              if (one_data) begin
                msg_valid_q  <= 1'b1;
                msg_status_q <= run_status_q;
                msg_data1_q  <= byte_in[6:0];
                msg_data2_q  <= 7'h00;
              end else begin
                state_q <= WAIT_D2;
              end
            end
            WAIT_D2: begin
              msg_valid_q  <= 1'b1;
              msg_status_q <= run_status_q;
              msg_data1_q  <= data1_q;
              msg_data2_q  <= byte_in[6:0];
              state_q      <= WAIT_D1;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.clr_rdy    = clr_rdy_q;
  assign bus.msg_valid  = msg_valid_q;
  assign bus.msg_status = msg_status_q;
  assign bus.msg_data1  = msg_data1_q;
  assign bus.msg_data2  = msg_data2_q;
  assign bus.rt_valid   = rt_valid_q;
  assign bus.rt_byte    = rt_byte_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_midi_parser.sv
// Directed and random byte streams against a queue-based MIDI message model.
module tb_midi_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  midi_parser_if bus();

  midi_parser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: running status, pending data bytes, drop count
  int   m_run = 0;
  int   m_pend[$];
  int   m_drops = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input int b, output bit emit, output int st,
                            output int d1, output int d2, output bit rt);
    int need;
    emit = 0; rt = 0; st = 0; d1 = 0; d2 = 0;
    if (b >= 'hF8) rt = 1;
    else if (b >= 'hF0) begin m_run = 0; m_pend.delete(); end
    else if (b >= 'h80) begin m_run = b; m_pend.delete(); end
    else if (m_run == 0) begin
      if (m_drops < 255) m_drops++;
    end else begin
      m_pend.push_back(b);
      need = (m_run >= 'hC0 && m_run <= 'hDF) ? 1 : 2;
      if (m_pend.size() == need) begin
        emit = 1; st = m_run; d1 = m_pend[0];
        d2 = (need == 2) ? m_pend[1] : 0;
        m_pend.delete();
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_clr"},  bus.clr_rdy, 0);
    chk({tag, "_mv"},   bus.msg_valid, 0);
    chk({tag, "_st"},   bus.msg_status, 0);
    chk({tag, "_d1"},   bus.msg_data1, 0);
    chk({tag, "_d2"},   bus.msg_data2, 0);
    chk({tag, "_rtv"},  bus.rt_valid, 0);
    chk({tag, "_rtb"},  bus.rt_byte, 0);
    chk({tag, "_drop"}, bus.drop_cnt, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.rx_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("rst");
    rst = 1'b0;
    m_run = 0; m_pend.delete(); m_drops = 0;
  endtask

  task automatic present(input int b);
    bus.rx_data = b[7:0];
    bus.rx_rdy  = 1'b1;
  endtask

  // Wait for the acknowledge, then check the outcome of that byte
  task automatic finish_byte(input int b);
    int n = 0;
    bit emit, rt;
    int st, d1, d2;
    do begin @(negedge clk); n++; end while (bus.clr_rdy !== 1'b1 && n < 50);
    chk("ack", bus.clr_rdy, 1);
    model_byte(b, emit, st, d1, d2, rt);
    $display("byte %02h: msg_valid=%0b st=%02h d1=%02h d2=%02h rt_valid=%0b drop=%0d",
             b, bus.msg_valid, bus.msg_status, bus.msg_data1, bus.msg_data2,
             bus.rt_valid, bus.drop_cnt);
    chk("msg_valid", bus.msg_valid, emit);
    if (emit) begin
      chk("msg_status", bus.msg_status, st);
      chk("msg_data1", bus.msg_data1, d1);
      chk("msg_data2", bus.msg_data2, d2);
    end
    chk("rt_valid", bus.rt_valid, rt);
    if (rt) chk("rt_byte", bus.rt_byte, b);
    chk("drop_cnt", bus.drop_cnt, m_drops);
    bus.rx_rdy = 1'b0;
    @(negedge clk);
    chk("clr_pulse", bus.clr_rdy, 0);
    chk("rt_pulse", bus.rt_valid, 0);
    if (bus.msg_ready) chk("msg_clear", bus.msg_valid, 0);
  endtask

  task automatic send(input int b);
    present(b);
    finish_byte(b);
  endtask

  initial begin
    int r, b;
    bus.rx_rdy = 1'b0; bus.rx_data = 8'h00; bus.msg_ready = 1'b1;
    do_reset();

    // Note-on, running status, velocity 0 kept as note-on
    send('h90); send('h3C); send('h64); send('h3E); send('h00);
    do_reset();
    // 1-data messages
    send('hC5); send('h07); send('h08);
    do_reset();
    // Real-time interleaved in a note
    send('h90); send('h3C); send('hF8); send('h64);
    do_reset();
    // Orphans and system bytes
    send('h40); send('h90); send('hF0); send('h01);
    chk("drop_two", bus.drop_cnt, 2);
    for (int i = 0; i < 258; i++) send($urandom_range(0, 127));
    chk("drop_sat", bus.drop_cnt, 255);

    // Backpressure
    do_reset();
    bus.msg_ready = 1'b0;
    send('h90); send('h3C); send('h64);
    present('h3E);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_clr", bus.clr_rdy, 0);
      chk("stall_mv", bus.msg_valid, 1);
      chk("stall_st", bus.msg_status, 'h90);
      chk("stall_d1", bus.msg_data1, 'h3C);
      chk("stall_d2", bus.msg_data2, 'h64);
    end
    bus.msg_ready = 1'b1;
    finish_byte('h3E);

    // Reset mid-message
    send('h91);
    send('h3C);
    do_reset();
    send('h40);
    chk("drop_after_rst", bus.drop_cnt, 1);

    // Random stream
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      b = $urandom_range(0, 127);
      else if (r <= 7) b = $urandom_range('h80, 'hEF);
      else if (r == 8) b = $urandom_range('hF8, 'hFF);
      else             b = $urandom_range('hF0, 'hF7);
      send(b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/midi_parser.md
# midi_parser

Byte-level MIDI message parser that sits directly downstream of the UART receiver. It consumes received bytes through the receiver's `rdy`/`clr_rdy` handshake and assembles complete channel-voice messages, including running status. Real-time bytes are passed through immediately on a side channel. Completed messages are presented on a valid/ready interface to the synth/control logic.

## Interface
- No parameters.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_rdy`  in  1  UART byte-available flag; level, held until cleared.
- `rx_data`  in  8  UART received byte; valid while `rx_rdy`=1.
- `clr_rdy`  out  1  one-cycle pulse acknowledging the byte to the UART.
- `msg_valid`  out  1  complete channel message available.
- `msg_ready`  in  1  consumer accepts the message when `msg_valid`=1.
- `msg_status`  out  8  status byte, 0x80–0xEF.
- `msg_data1`  out  7  first data byte.
- `msg_data2`  out  7  second data byte; 0 for 1-data messages.
- `rt_valid`  out  1  one-cycle pulse for a real-time byte.
- `rt_byte`  out  8  real-time byte, 0xF8–0xFF; holds its last value.
- `drop_cnt`  out  8  saturating count of discarded data bytes.

## Operation
- **Accept condition:** `accept = rx_rdy & ~clr_rdy & ~stall`, where `stall = msg_valid & ~msg_ready`.
  - `clr_rdy` is registered: it equals `accept` delayed by one cycle.
  - The `~clr_rdy` term prevents the same byte from being consumed twice while the UART clears `rdy`.
- **Byte classes** (evaluated only on `accept`):
  - **0xF8–0xFF (real-time):** pulse `rt_valid` and load `rt_byte`. Parser state, running status and partial data are untouched.
  - **0x80–0xEF (channel status):** load running status and set the expected data length.
    - Length = 1 for 0xC0–0xDF; 2 otherwise.
    - Any partial message in progress is abandoned silently.
    - State goes to WAIT_D1.
  - **0xF0–0xF7 (SysEx/system common):** clear running status and go to IDLE. No message is emitted.
  - **0x00–0x7F (data):** handled per state, below.
- **States:**
  - **IDLE** (no running status): a data byte is discarded and `drop_cnt` increments, saturating at 255.
  - **WAIT_D1:**
    - Store the byte as `data1`.
    - If length = 1: emit the message with `data2`=0 and stay in WAIT_D1 (running status).
    - Otherwise go to WAIT_D2.
  - **WAIT_D2:** store the byte as `data2`, emit the message, return to WAIT_D1.
- **Emit:** load the `msg_*` registers and set `msg_valid`.
  - Outputs stay stable while `msg_valid & ~msg_ready`.
  - `msg_valid` clears on the cycle after a cycle with `msg_valid & msg_ready`, unless a new emit occurs in that same cycle.
  - An emit and a handshake in the same cycle leave `msg_valid`=1 with the new contents.
- Note-on with velocity 0 is passed through unchanged; no conversion to note-off.
- **Reset:**
  - All outputs are 0: `clr_rdy`, `msg_valid`, `msg_status`, `msg_data1`, `msg_data2`, `rt_valid`, `rt_byte`, `drop_cnt`.
  - State is IDLE and running status is cleared.
  - Reset mid-message discards the partial message.

## Timing
- Byte accepted in cycle N:
  - `clr_rdy`=1 in N+1.
  - `rt_valid` or `msg_valid` is visible in N+1.
- Back-to-back byte acceptance is at most one every 2 cycles. The UART byte time (≥320 clk at typical `clk_div`) makes this irrelevant for throughput.
- Backpressure: while stalled, no byte is accepted, `clr_rdy` stays 0, and the UART byte is held. This includes real-time bytes.
- `rt_valid` never stalls and is never held more than one cycle.

## Test plan
- **Note-on:** after reset, bytes 0x90, 0x3C, 0x64 with `msg_ready`=1 -> three `clr_rdy` pulses; one `msg_valid` with status 0x90, d1 0x3C, d2 0x64.
- **Running status:** 0x90, 0x3C, 0x64, 0x3E, 0x00 -> two messages: (0x90, 0x3C, 0x64) and (0x90, 0x3E, 0x00).
- **1-data message:** 0xC5, 0x07, 0x08 -> messages (0xC5, 0x07, 0x00) and (0xC5, 0x08, 0x00).
- **Real-time interleave:** 0x90, 0x3C, 0xF8, 0x64 -> `rt_valid` pulse with `rt_byte`=0xF8 between the bytes; note message (0x90, 0x3C, 0x64) is intact.
- **Orphans and system bytes:**
  - 0x40 right after reset -> no message, `drop_cnt`=1.
  - Then 0x90, 0xF0, 0x01 -> no message, `drop_cnt`=2.
  - 256+ orphan bytes -> `drop_cnt` saturates at 255.
- **Backpressure:**
  - With `msg_ready`=0, complete a note; present the next byte 0x3E -> no `clr_rdy`, `msg_*` held for 20 cycles.
  - Raise `msg_ready` -> `msg_valid` drops, 0x3E is accepted.
  - Assert `rst` mid-message -> all outputs 0, and the next data byte increments `drop_cnt`.
